// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, instruction classes,
// state encoding, the strobe bundle and the opcode-to-class decoder.
package ctrl_pkg;

    localparam logic [4:0] OP_LD      = 5'b00000;
    localparam logic [4:0] OP_LDI     = 5'b00001;
    localparam logic [4:0] OP_ST      = 5'b00010;
    localparam logic [4:0] OP_RALU_LO = 5'b00011;
    localparam logic [4:0] OP_RALU_HI = 5'b01011;
    localparam logic [4:0] OP_IALU_LO = 5'b01100;
    localparam logic [4:0] OP_IALU_HI = 5'b01110;
    localparam logic [4:0] OP_MUL     = 5'b01111;
    localparam logic [4:0] OP_DIV     = 5'b10000;
    localparam logic [4:0] OP_BR      = 5'b10010;
    localparam logic [4:0] OP_MFHI    = 5'b11000;
    localparam logic [4:0] OP_MFLO    = 5'b11001;
    localparam logic [4:0] OP_NOP     = 5'b11010;
    localparam logic [4:0] OP_HALT    = 5'b11011;

    // ALU operation used for address and branch-target arithmetic.
    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        R_ALU, I_ALU, LDI, LD, ST, MULDIV, BR, MFHI, MFLO, NOP, HALT, ILL
    } op_class_e;

    typedef enum logic [3:0] {
        RESET, F0, F1, F2, E3, E4, E5, E6, E7, STOPPED, HALTED
    } state_e;

    // Every datapath strobe the sequencer can raise.
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhi_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic c_out;
        logic ba_out;
        logic r_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic r_in;
        logic con_in;
        logic inc_pc;
        logic gra;
        logic grb;
        logic grc;
        logic read;
        logic write;
    } strobes_t;

    function automatic op_class_e decode_class(input logic [4:0] op);
        if (op >= OP_RALU_LO && op <= OP_RALU_HI) return R_ALU;
        if (op >= OP_IALU_LO && op <= OP_IALU_HI) return I_ALU;
        case (op)
            OP_LDI:         return LDI;
            OP_LD:          return LD;
            OP_ST:          return ST;
            OP_MUL, OP_DIV: return MULDIV;
            OP_BR:          return BR;
            OP_MFHI:        return MFHI;
            OP_MFLO:        return MFLO;
            OP_NOP:         return NOP;
            OP_HALT:        return HALT;
            default:        return ILL;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that stretches memory steps: reloads MEM_WAIT outside a wait
// step and counts down inside one; zero marks the step's final cycle.
module mem_wait_counter #(
    parameter int MEM_WAIT = 0
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    logic [3:0] count;

    // Count register: clear wins, then reload, then decrement.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= WAIT_INIT;
        end else if (dec) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch, then a class-dependent execute
// sequence decoded from the IR opcode, with memory waits, stop and halt.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OP_W     = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] IR,
    input  logic              CON_FF,
    input  logic              Stop,
    output logic              PCout,
    output logic              Zlowout,
    output logic              Zhiout,
    output logic              MDRout,
    output logic              HIout,
    output logic              LOout,
    output logic              Cout,
    output logic              BAout,
    output logic              Rout,
    output logic              PCin,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              Yin,
    output logic              Zin,
    output logic              HIin,
    output logic              LOin,
    output logic              Rin,
    output logic              CONin,
    output logic              IncPC,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Read,
    output logic              Write,
    output logic [OP_W-1:0]   alu_op,
    output logic              Run,
    output logic              Illegal
);

    state_e    state;
    state_e    next_state;
    state_e    last_next;
    op_class_e cls;
    strobes_t  strb;
    logic [OP_W-1:0] opcode;
    logic      in_wait;
    logic      wait_zero;
    logic      unused_ir;

    assign opcode    = IR[DATA_W-1 -: OP_W];
    assign unused_ir = ^IR[DATA_W-OP_W-1:0];
    assign cls       = decode_class(opcode);

    // A step is stretched by the memory wait in F1, LD-E6 and ST-E7 only.
    assign in_wait = (state == F1) ||
                     (state == E6 && cls == LD) ||
                     (state == E7 && cls == ST);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clock (Clock),
        .clear (Clear),
        .load  (!in_wait),
        .dec   (in_wait && !wait_zero),
        .zero  (wait_zero)
    );

    // State register; Clear forces RESET from any state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: step through the class sequence, honour waits and Stop.
    // NOTE: every variable gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        last_next  = Stop ? STOPPED : F0;
        next_state = state;
        unique case (state)
            RESET:   next_state = F0;
            F0:      next_state = F1;
            F1:      if (wait_zero) next_state = F2;
            F2:      next_state = E3;
            E3: begin
                case (cls)
                    HALT:                 next_state = HALTED;
                    MFHI, MFLO, NOP, ILL: next_state = last_next;
                    default:              next_state = E4;
                endcase
            end
            E4:      next_state = E5;
            E5: begin
                case (cls)
                    R_ALU, I_ALU, LDI: next_state = last_next;
                    default:           next_state = E6;
                endcase
            end
            E6: begin
                case (cls)
                    LD:      if (wait_zero) next_state = E7;
                    ST:      next_state = E7;
                    default: next_state = last_next;
                endcase
            end
            E7: begin
                if (cls != ST || wait_zero) next_state = last_next;
            end
            STOPPED: if (!Stop) next_state = F0;
            HALTED:  next_state = HALTED;
            default: next_state = RESET;
        endcase
    end

    // Moore output decode from state and instruction class.
    always_comb begin
        strb    = '0;
        alu_op  = '0;
        Illegal = 1'b0;
        unique case (state)
            F0: begin
                strb.pc_out = 1'b1; strb.mar_in = 1'b1;
                strb.inc_pc = 1'b1; strb.z_in   = 1'b1;
            end
            F1: begin
                strb.zlow_out = 1'b1; strb.pc_in  = 1'b1;
                strb.read     = 1'b1; strb.mdr_in = 1'b1;
            end
            F2: begin
                strb.mdr_out = 1'b1; strb.ir_in = 1'b1;
            end
            E3: begin
                case (cls)
                    R_ALU, I_ALU, LDI: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
                    LD, ST:            begin strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1; end
                    MULDIV:            begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
                    BR:                begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_in = 1'b1; end
                    MFHI:              begin strb.hi_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    MFLO:              begin strb.lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    ILL:               Illegal = 1'b1;
                    default:           ;
                endcase
            end
            E4: begin
                case (cls)
                    R_ALU: begin
                        strb.grc = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1;
                        alu_op = opcode;
                    end
                    I_ALU, LDI: begin
                        strb.c_out = 1'b1; strb.z_in = 1'b1;
                        alu_op = (cls == LDI) ? OP_W'(ALU_ADD) : opcode;
                    end
                    LD, ST: begin
                        strb.c_out = 1'b1; strb.z_in = 1'b1;
                        alu_op = OP_W'(ALU_ADD);
                    end
                    MULDIV: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1;
                        alu_op = opcode;
                    end
                    BR:      begin strb.pc_out = 1'b1; strb.y_in = 1'b1; end
                    default: ;
                endcase
            end
            E5: begin
                case (cls)
                    R_ALU, I_ALU, LDI: begin strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    LD, ST:            begin strb.zlow_out = 1'b1; strb.mar_in = 1'b1; end
                    MULDIV:            begin strb.zlow_out = 1'b1; strb.lo_in = 1'b1; end
                    BR: begin
                        strb.c_out = 1'b1; strb.z_in = 1'b1;
                        alu_op = OP_W'(ALU_ADD);
                    end
                    default: ;
                endcase
            end
            E6: begin
                case (cls)
                    LD:      begin strb.read = 1'b1; strb.mdr_in = 1'b1; end
                    ST:      begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.mdr_in = 1'b1; end
                    MULDIV:  begin strb.zhi_out = 1'b1; strb.hi_in = 1'b1; end
                    BR:      begin strb.zlow_out = 1'b1; strb.pc_in = CON_FF; end
                    default: ;
                endcase
            end
            E7: begin
                case (cls)
                    LD:      begin strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    ST:      strb.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign Run = !(state == RESET || state == STOPPED || state == HALTED);

    assign PCout   = strb.pc_out;
    assign Zlowout = strb.zlow_out;
    assign Zhiout  = strb.zhi_out;
    assign MDRout  = strb.mdr_out;
    assign HIout   = strb.hi_out;
    assign LOout   = strb.lo_out;
    assign Cout    = strb.c_out;
    assign BAout   = strb.ba_out;
    assign Rout    = strb.r_out;
    assign PCin    = strb.pc_in;
    assign IRin    = strb.ir_in;
    assign MARin   = strb.mar_in;
    assign MDRin   = strb.mdr_in;
    assign Yin     = strb.y_in;
    assign Zin     = strb.z_in;
    assign HIin    = strb.hi_in;
    assign LOin    = strb.lo_in;
    assign Rin     = strb.r_in;
    assign CONin   = strb.con_in;
    assign IncPC   = strb.inc_pc;
    assign Gra     = strb.gra;
    assign Grb     = strb.grb;
    assign Grc     = strb.grc;
    assign Read    = strb.read;
    assign Write   = strb.write;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: three sequencers (MEM_WAIT 0, 2, 3) share stimulus;
// the one under test is released from Clear, the others are held in reset.
// An instruction-level model expands each opcode into its expected per-cycle
// output vector; one compare process checks the active DUT every cycle.
module tb_control_sequencer;

    // Expected/observed vector layout: {Illegal, Run, alu_op[4:0], strobes[24:0]}
    localparam logic [24:0] M_PCOUT   = 25'h0000001;
    localparam logic [24:0] M_ZLOWOUT = 25'h0000002;
    localparam logic [24:0] M_ZHIOUT  = 25'h0000004;
    localparam logic [24:0] M_MDROUT  = 25'h0000008;
    localparam logic [24:0] M_HIOUT   = 25'h0000010;
    localparam logic [24:0] M_LOOUT   = 25'h0000020;
    localparam logic [24:0] M_COUT    = 25'h0000040;
    localparam logic [24:0] M_BAOUT   = 25'h0000080;
    localparam logic [24:0] M_ROUT    = 25'h0000100;
    localparam logic [24:0] M_PCIN    = 25'h0000200;
    localparam logic [24:0] M_IRIN    = 25'h0000400;
    localparam logic [24:0] M_MARIN   = 25'h0000800;
    localparam logic [24:0] M_MDRIN   = 25'h0001000;
    localparam logic [24:0] M_YIN     = 25'h0002000;
    localparam logic [24:0] M_ZIN     = 25'h0004000;
    localparam logic [24:0] M_HIIN    = 25'h0008000;
    localparam logic [24:0] M_LOIN    = 25'h0010000;
    localparam logic [24:0] M_RIN     = 25'h0020000;
    localparam logic [24:0] M_CONIN   = 25'h0040000;
    localparam logic [24:0] M_INCPC   = 25'h0080000;
    localparam logic [24:0] M_GRA     = 25'h0100000;
    localparam logic [24:0] M_GRB     = 25'h0200000;
    localparam logic [24:0] M_GRC     = 25'h0400000;
    localparam logic [24:0] M_READ    = 25'h0800000;
    localparam logic [24:0] M_WRITE   = 25'h1000000;
    localparam logic [4:0]  ADD       = 5'b00011;

    logic        Clock = 1'b0;
    logic [2:0]  clr = 3'b111;
    logic [31:0] IR = '0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic [2:0][31:0] obs;

    int          checks = 0;
    int          errors = 0;
    int          cur = 0;
    int          cur_idx = 0;
    string       cur_name = "idle";
    logic [31:0] seq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic pc_out, zlow_out, zhi_out, mdr_out, hi_out, lo_out, c_out, ba_out, r_out;
        logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, r_in, con_in, inc_pc;
        logic gra, grb, grc, rd, wr, run, ill;
        logic [4:0] alu;

        control_sequencer #(.DATA_W(32), .OP_W(5), .MEM_WAIT((g == 0) ? 0 : g + 1)) u_dut (
            .Clock(Clock), .Clear(clr[g]), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
            .PCout(pc_out), .Zlowout(zlow_out), .Zhiout(zhi_out), .MDRout(mdr_out),
            .HIout(hi_out), .LOout(lo_out), .Cout(c_out), .BAout(ba_out), .Rout(r_out),
            .PCin(pc_in), .IRin(ir_in), .MARin(mar_in), .MDRin(mdr_in), .Yin(y_in),
            .Zin(z_in), .HIin(hi_in), .LOin(lo_in), .Rin(r_in), .CONin(con_in),
            .IncPC(inc_pc), .Gra(gra), .Grb(grb), .Grc(grc), .Read(rd), .Write(wr),
            .alu_op(alu), .Run(run), .Illegal(ill)
        );

        assign obs[g] = {ill, run, alu, wr, rd, grc, grb, gra, inc_pc, con_in, r_in,
                         lo_in, hi_in, z_in, y_in, mdr_in, mar_in, ir_in, pc_in,
                         r_out, ba_out, c_out, lo_out, hi_out, mdr_out, zhi_out,
                         zlow_out, pc_out};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    // Append n cycles of an executing step (Run=1, Illegal=0).
    task automatic add(input logic [24:0] m, input logic [4:0] alu, input int n);
        repeat (n) seq.push_back({2'b01, alu, m});
    endtask

    // Expand one instruction into its per-cycle expected outputs.
    task automatic gen_instr(input logic [4:0] op, input int w, input logic con);
        seq.delete();
        add(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1);
        add(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1 + w);
        add(M_MDROUT | M_IRIN, 5'd0, 1);
        case (op) inside
            [5'd3:5'd11]: begin
                add(M_GRB | M_ROUT | M_YIN, 5'd0, 1);
                add(M_GRC | M_ROUT | M_ZIN, op, 1);
                add(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1);
            end
            [5'd12:5'd14], 5'd1: begin
                add(M_GRB | M_ROUT | M_YIN, 5'd0, 1);
                add(M_COUT | M_ZIN, (op == 5'd1) ? ADD : op, 1);
                add(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1);
            end
            5'd0, 5'd2: begin
                add(M_GRB | M_BAOUT | M_YIN, 5'd0, 1);
                add(M_COUT | M_ZIN, ADD, 1);
                add(M_ZLOWOUT | M_MARIN, 5'd0, 1);
                if (op == 5'd0) begin
                    add(M_READ | M_MDRIN, 5'd0, 1 + w);
                    add(M_MDROUT | M_GRA | M_RIN, 5'd0, 1);
                end else begin
                    add(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1);
                    add(M_WRITE, 5'd0, 1 + w);
                end
            end
            5'd15, 5'd16: begin
                add(M_GRA | M_ROUT | M_YIN, 5'd0, 1);
                add(M_GRB | M_ROUT | M_ZIN, op, 1);
                add(M_ZLOWOUT | M_LOIN, 5'd0, 1);
                add(M_ZHIOUT | M_HIIN, 5'd0, 1);
            end
            5'd18: begin
                add(M_GRA | M_ROUT | M_CONIN, 5'd0, 1);
                add(M_PCOUT | M_YIN, 5'd0, 1);
                add(M_COUT | M_ZIN, ADD, 1);
                add(M_ZLOWOUT | (con ? M_PCIN : 25'd0), 5'd0, 1);
            end
            5'd24:        add(M_HIOUT | M_GRA | M_RIN, 5'd0, 1);
            5'd25:        add(M_LOOUT | M_GRA | M_RIN, 5'd0, 1);
            5'd26, 5'd27: add(25'd0, 5'd0, 1);
            default:      seq.push_back(32'hC000_0000);
        endcase
    endtask

    // Queue one cycle's expectation and advance to just after the next edge.
    task automatic step(input logic [31:0] v);
        exp_q.push_back(v);
        @(posedge Clock);
        #1;
    endtask

    // Run one instruction; optionally raise Stop at a cycle index and hold it
    // for stop_hold STOPPED cycles before releasing.
    task automatic run(input logic [4:0] op, input logic con, input int stop_from,
                       input int stop_hold, input string name);
        gen_instr(op, wait_of(cur), con);
        IR       = {op, 27'h0ABCDE};
        CON_FF   = con;
        cur_name = name;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == stop_from) Stop = 1'b1;
            cur_idx = i;
            step(seq[i]);
        end
        if (stop_from >= 0) begin
            for (int k = 0; k <= stop_hold; k++) begin
                if (k == stop_hold) Stop = 1'b0;
                cur_idx = 100 + k;
                step(32'h0);
            end
        end
    endtask

    // Hold everything in Clear, then release only instance k; leaves it in F0.
    task automatic start(input int k);
        clr = 3'b111;
        cur = k;
        cur_name = "reset";
        cur_idx = 0;
        @(posedge Clock);
        #1;
        clr[k] = 1'b0;
        step(32'h0);
    endtask

    // Compare the active DUT against the model once per cycle, mid-cycle.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check($sformatf("%s[%0d]", cur_name, cur_idx), obs[cur], exp_v);
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int reads;

        // Literal pins on the model itself.
        gen_instr(5'd12, 0, 1'b0);
        check("pin_addi_len", seq.size(), 32'd6);
        check("pin_addi_e4", seq[4], 32'h5800_4040);
        check("pin_addi_e5", seq[5], 32'h4012_0002);
        gen_instr(5'd0, 2, 1'b0);
        reads = 0;
        foreach (seq[i]) if (seq[i][23]) reads++;
        check("pin_ld_len", seq.size(), 32'd12);
        check("pin_ld_reads", reads, 32'd6);
        check("pin_ld_e7", seq[11], 32'h4012_0008);
        gen_instr(5'd18, 0, 1'b1);
        check("pin_br1_e6", seq[6], 32'h4000_0202);
        gen_instr(5'd18, 0, 1'b0);
        check("pin_br0_e6", seq[6], 32'h4000_0002);
        gen_instr(5'd15, 0, 1'b0);
        check("pin_mul_len", seq.size(), 32'd7);
        check("pin_mul_e5", seq[5], 32'h4001_0002);
        check("pin_mul_e6", seq[6], 32'h4000_8004);
        gen_instr(5'd31, 0, 1'b0);
        check("pin_ill_len", seq.size(), 32'd4);
        check("pin_ill_e3", seq[3], 32'hC000_0000);
        seq.delete();

        // MEM_WAIT = 0
        start(0);
        check("w0_first_f0", obs[cur], 32'h4008_4801);
        run(5'd12, 1'b0, -1, 0, "addi");
        run(5'd4,  1'b0, -1, 0, "sub");
        run(5'd1,  1'b0, -1, 0, "ldi");
        run(5'd0,  1'b0, -1, 0, "ld_w0");
        run(5'd2,  1'b0, -1, 0, "st_w0");
        run(5'd15, 1'b0, -1, 0, "mul");
        run(5'd16, 1'b0, -1, 0, "div");
        run(5'd18, 1'b0, -1, 0, "br_c0");
        run(5'd18, 1'b1, -1, 0, "br_c1");
        run(5'd24, 1'b0, -1, 0, "mfhi");
        run(5'd25, 1'b0, -1, 0, "mflo");
        run(5'd26, 1'b0, -1, 0, "nop");
        run(5'd31, 1'b0, -1, 0, "ill31");
        run(5'd17, 1'b0, -1, 0, "ill17");
        run(5'd4,  1'b0, 4, 2, "sub_stop");
        run(5'd14, 1'b0, 2, 0, "ialu_stop_resume");
        run(5'd26, 1'b0, -1, 0, "nop_after_stop");
        run(5'd27, 1'b0, -1, 0, "halt");
        cur_name = "halted";
        for (int i = 0; i < 20; i++) begin
            cur_idx = i;
            step(32'h0);
        end
        check("halted_still", obs[cur], 32'h0);

        // MEM_WAIT = 2
        start(1);
        run(5'd0,  1'b0, -1, 0, "ld_w2");
        run(5'd2,  1'b0, -1, 0, "st_w2");
        run(5'd12, 1'b0, -1, 0, "addi_w2");
        run(5'd31, 1'b0, -1, 0, "ill_w2");
        run(5'd18, 1'b1, 6, 1, "br_w2_stop");

        // MEM_WAIT = 3: Clear in the middle of the LD-E6 wait
        start(2);
        gen_instr(5'd0, 3, 1'b0);
        IR = {5'd0, 27'h0ABCDE};
        cur_name = "ld_w3_clr";
        for (int i = 0; i <= 10; i++) begin
            cur_idx = i;
            step(seq[i]);
        end
        clr[2] = 1'b1;
        cur_idx = 11;
        step(seq[11]);
        check("clear_all_zero", obs[cur], 32'h0);
        clr[2] = 1'b0;
        cur_idx = 12;
        step(32'h0);
        check("clear_then_f0", obs[cur], 32'h4008_4801);
        run(5'd0,  1'b0, -1, 0, "ld_w3");
        run(5'd12, 1'b0, -1, 0, "addi_w3");

        @(negedge Clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
